reg_array_arbiter: RTL and testbench

- Shares one DEPTH x DATA_W register array between two requesters (ports 0 and 1), each able to issue single-word reads or writes.
- A small FSM sequences every access: arbitrate, access, release.
- Round-robin arbitration on ties.
- Sits between V#-generated state machines and the register array they previously wrote directly, so multiple FSMs can share one array.

---
 rtl/reg_array_arbiter_pkg.sv | 16 +
 rtl/reg_array_arbiter_rr_pick.sv | 34 +++
 rtl/reg_array_arbiter.sv | 137 +++++++++++++
 tb/tb_reg_array_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_array_arbiter_pkg.sv
// rtl/reg_array_arbiter_pkg.sv - state encoding and default sizes for the shared register-array arbiter
package reg_array_arbiter_pkg;

   localparam int STATE_W    = 2;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 2;

   // Encoding 3 is HOLD only when REGARB_LOCK_EN is defined; otherwise it recovers to ARB
   typedef enum logic [STATE_W-1:0] {
      ST_ARB     = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RELEASE = 2'd2,
      ST_HOLD    = 2'd3
   } state_e;

endpackage

// File: rtl/reg_array_arbiter_rr_pick.sv
// rtl/reg_array_arbiter_rr_pick.sv - two-way round-robin picker with its last_grant flop
module regarb_rr_pick (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic advance,
   output logic grant_valid,
   output logic grant_idx
);

   logic last_grant_q;
   logic last_grant_d;

   // Pick the lone requester, or on a tie the port that was not served last
   always_comb begin
      grant_valid  = req0 | req1;
      grant_idx    = (req0 && req1) ? ~last_grant_q : (req1 & ~req0);
      last_grant_d = last_grant_q;
      if (advance && grant_valid) begin
         last_grant_d = grant_idx;
      end
   end

   // Remember the last served port; starts at 1 so port 0 wins the first tie
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/reg_array_arbiter.sv
// rtl/reg_array_arbiter.sv - two-port arbiter in front of a DEPTH x DATA_W register array (optional REGARB_LOCK_EN)
module reg_array_arbiter
   import reg_array_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0,
   input  logic               req1,
   input  logic               we0,
   input  logic               we1,
   input  logic [ADDR_W-1:0]  addr0,
   input  logic [ADDR_W-1:0]  addr1,
   input  logic [DATA_W-1:0]  wdata0,
   input  logic [DATA_W-1:0]  wdata1,
`ifdef REGARB_LOCK_EN
   input  logic               lock0,
   input  logic               lock1,
`endif
   output logic               ack0,
   output logic               ack1,
   output logic [DATA_W-1:0]  rdata0,
   output logic [DATA_W-1:0]  rdata1,
   output logic               busy,
   output logic [STATE_W-1:0] state
);

   localparam int DEPTH = 2 ** ADDR_W;

   state_e              state_q;
   logic                ack0_q, ack1_q;
   logic [DATA_W-1:0]   rdata0_q, rdata1_q;
   logic                hold_idx_q;
   logic                hold_we_q;
   logic [ADDR_W-1:0]   hold_addr_q;
   logic [DATA_W-1:0]   hold_wdata_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                grant_valid, grant_idx;
   logic                sel_idx, sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   regarb_rr_pick u_pick (
      .clk         (clk),
      .reset       (reset),
      .req0        (req0),
      .req1        (req1),
      .advance     (state_q == ST_ARB),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Route the chosen port's request fields: the arbiter's pick, or the locked owner while in HOLD
   always_comb begin
      sel_idx   = (state_q == ST_HOLD) ? hold_idx_q : grant_idx;
      sel_we    = sel_idx ? we1    : we0;
      sel_addr  = sel_idx ? addr1  : addr0;
      sel_wdata = sel_idx ? wdata1 : wdata0;
   end

   // Sequencer: arbitrate, perform the single array access, then pulse the winner's ack
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_ARB;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         hold_idx_q   <= 1'b0;
         hold_we_q    <= 1'b0;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            ST_ARB: begin
               if (grant_valid) begin
                  hold_idx_q   <= sel_idx;
                  hold_we_q    <= sel_we;
                  hold_addr_q  <= sel_addr;
                  hold_wdata_q <= sel_wdata;
                  state_q      <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (hold_we_q) begin
                  mem_q[hold_addr_q] <= hold_wdata_q;
               end else if (hold_idx_q) begin
                  rdata1_q <= mem_q[hold_addr_q];
               end else begin
                  rdata0_q <= mem_q[hold_addr_q];
               end
               ack0_q  <= ~hold_idx_q;
               ack1_q  <= hold_idx_q;
               state_q <= ST_RELEASE;
            end
            ST_RELEASE: begin
`ifdef REGARB_LOCK_EN
               state_q <= (hold_idx_q ? lock1 : lock0) ? ST_HOLD : ST_ARB;
`else
               state_q <= ST_ARB;
`endif
            end
            default: begin
`ifdef REGARB_LOCK_EN
               // HOLD: the lock owner re-enters ACCESS directly, skipping arbitration
               if ((hold_idx_q ? req1 : req0) && (hold_idx_q ? lock1 : lock0)) begin
                  hold_we_q    <= sel_we;
                  hold_addr_q  <= sel_addr;
                  hold_wdata_q <= sel_wdata;
                  state_q      <= ST_ACCESS;
               end else begin
                  state_q <= ST_ARB;
               end
`else
               state_q <= ST_ARB;
`endif
            end
         endcase
      end
   end

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;
   assign busy   = (state_q != ST_ARB);
   assign state  = state_q;

endmodule

// File: tb/tb_reg_array_arbiter.sv
// tb/tb_reg_array_arbiter.sv - scoreboard bench for reg_array_arbiter (lock tests follow REGARB_LOCK_EN)
module tb_reg_array_arbiter;

   localparam int DW = 32;
   localparam int AW = 2;

   typedef struct {
      int          port;
      bit          rd;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
`ifdef REGARB_LOCK_EN
   logic          lock0, lock1;
`endif
   logic          ack0, ack1, busy;
   logic [DW-1:0] rdata0, rdata1;
   logic [1:0]    state;

   exp_t          sb_q[$];
   logic [DW-1:0] model [4];
   int            n_cmp = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   reg_array_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk    (clk),
      .reset  (reset),
      .req0   (req0),
      .req1   (req1),
      .we0    (we0),
      .we1    (we1),
      .addr0  (addr0),
      .addr1  (addr1),
      .wdata0 (wdata0),
      .wdata1 (wdata1),
`ifdef REGARB_LOCK_EN
      .lock0  (lock0),
      .lock1  (lock1),
`endif
      .ack0   (ack0),
      .ack1   (ack1),
      .rdata0 (rdata0),
      .rdata1 (rdata1),
      .busy   (busy),
      .state  (state)
   );

   task automatic drive(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
   endtask

   task automatic drop(input int p);
      if (p == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) model[i] = '0;
   endtask

   task automatic expect_xact(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.port = p;
      e.rd   = !we;
      e.data = we ? d : model[a];
      if (we) model[a] = d;
      sb_q.push_back(e);
   endtask

   task automatic wait_ack(input int budget, output int port, output int cyc);
      port = -1;
      cyc  = 0;
      while (port < 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (ack0 && ack1) port = 2;
         else if (ack0)    port = 0;
         else if (ack1)    port = 1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if ({ack0, ack1} !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b expected 00", {ack0, ack1}); end
      n_cmp++; if (rdata0 !== '0) begin n_bad++; $display("FAIL reset_rdata0: got %h expected 0", rdata0); end
      n_cmp++; if (rdata1 !== '0) begin n_bad++; $display("FAIL reset_rdata1: got %h expected 0", rdata1); end
      reset = 1'b1;
      clear_model();
      @(negedge clk);
   endtask

   task automatic test_read_zero();
      int port, cyc;
      exp_t e;
      drive(0, 1'b0, 2'd3, '0);
      expect_xact(0, 1'b0, 2'd3, '0);
      port = -1; cyc = 0;
      while (port < 0 && cyc < 8) begin
         @(negedge clk);
         cyc++;
         n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL read0_busy: got %b expected 1 at cycle %0d", busy, cyc); end
         if (ack0) port = 0; else if (ack1) port = 1;
      end
      drop(0);
      e = sb_q.pop_front();
      n_cmp++; if (port !== e.port) begin n_bad++; $display("FAIL read0_port: got %0d expected %0d", port, e.port); end
      n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL read0_latency: got %0d expected 2", cyc); end
      n_cmp++; if (rdata0 !== e.data) begin n_bad++; $display("FAIL read0_rdata: got %h expected %h", rdata0, e.data); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || state !== 2'd0) begin n_bad++; $display("FAIL read0_idle: got busy=%b state=%0d expected 0/0", busy, state); end
   endtask

   task automatic test_raw();
      int port, cyc;
      exp_t e;
      drive(0, 1'b1, 2'd3, 32'h123);
      expect_xact(0, 1'b1, 2'd3, 32'h123);
      wait_ack(8, port, cyc);
      drop(0);
      e = sb_q.pop_front();
      n_cmp++; if (port !== e.port || cyc !== 2) begin n_bad++; $display("FAIL raw_write_ack: got port %0d cyc %0d expected port %0d cyc 2", port, cyc, e.port); end
      @(negedge clk);
      drive(1, 1'b0, 2'd3, '0);
      expect_xact(1, 1'b0, 2'd3, '0);
      wait_ack(8, port, cyc);
      drop(1);
      e = sb_q.pop_front();
      n_cmp++; if (port !== e.port) begin n_bad++; $display("FAIL raw_read_port: got %0d expected %0d", port, e.port); end
      n_cmp++; if (rdata1 !== e.data) begin n_bad++; $display("FAIL raw_rdata1: got %h expected %h", rdata1, e.data); end
      n_cmp++; if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL raw_rdata0_hold: got %h expected 0", rdata0); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int port, cyc, cnt0, cnt1;
      exp_t e;
      logic [DW-1:0] v0, v1;
      v0 = 32'h1111_0000; v1 = 32'h2222_0000;
      cnt0 = 0; cnt1 = 0;
      drive(0, 1'b1, 2'd0, v0);
      drive(1, 1'b1, 2'd1, v1);
      expect_xact(0, 1'b1, 2'd0, v0);
      expect_xact(1, 1'b1, 2'd1, v1);
      expect_xact(0, 1'b1, 2'd0, v0 + 1);
      expect_xact(1, 1'b1, 2'd1, v1 + 1);
      for (int k = 0; k < 4; k++) begin
         wait_ack(10, port, cyc);
         e = sb_q.pop_front();
         n_cmp++; if (port !== e.port) begin n_bad++; $display("FAIL b2b_order[%0d]: got port %0d expected %0d", k, port, e.port); end
         n_cmp++; if (cyc !== ((k == 0) ? 2 : 3)) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", k, cyc, (k == 0) ? 2 : 3); end
         if (port == 0) begin cnt0++; wdata0 = v0 + cnt0; end
         else if (port == 1) begin cnt1++; wdata1 = v1 + cnt1; end
      end
      drop(0); drop(1);
      @(negedge clk);
      n_cmp++; if (rdata1 !== 32'h123) begin n_bad++; $display("FAIL b2b_rdata1_hold: got %h expected 00000123", rdata1); end
      drive(1, 1'b0, 2'd0, '0);
      expect_xact(1, 1'b0, 2'd0, '0);
      wait_ack(8, port, cyc);
      drop(1);
      e = sb_q.pop_front();
      n_cmp++; if (port !== e.port || rdata1 !== e.data) begin n_bad++; $display("FAIL b2b_readback0: got port %0d data %h expected port %0d data %h", port, rdata1, e.port, e.data); end
      @(negedge clk);
      drive(0, 1'b0, 2'd1, '0);
      expect_xact(0, 1'b0, 2'd1, '0);
      wait_ack(8, port, cyc);
      drop(0);
      e = sb_q.pop_front();
      n_cmp++; if (port !== e.port || rdata0 !== e.data) begin n_bad++; $display("FAIL b2b_readback1: got port %0d data %h expected port %0d data %h", port, rdata0, e.port, e.data); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int port, cyc;
      exp_t e;
      drive(1, 1'b1, 2'd2, 32'hABC);
      @(negedge clk);
      n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL rstmid_access: got state %0d expected 1", state); end
      reset = 1'b0;
      #1;
      n_cmp++; if (state !== 2'd0 || ack1 !== 1'b0) begin n_bad++; $display("FAIL rstmid_abort: got state %0d ack1 %b expected 0/0", state, ack1); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (ack1 !== 1'b0) begin n_bad++; $display("FAIL rstmid_noack[%0d]: got %b expected 0", i, ack1); end
      end
      drop(1);
      reset = 1'b1;
      clear_model();
      @(negedge clk);
      n_cmp++; if (rdata1 !== '0) begin n_bad++; $display("FAIL rstmid_rdata1: got %h expected 0", rdata1); end
      drive(0, 1'b0, 2'd2, '0);
      expect_xact(0, 1'b0, 2'd2, '0);
      wait_ack(8, port, cyc);
      drop(0);
      e = sb_q.pop_front();
      n_cmp++; if (port !== e.port || rdata0 !== e.data) begin n_bad++; $display("FAIL rstmid_readback: got port %0d data %h expected port %0d data %h", port, rdata0, e.port, e.data); end
      @(negedge clk);
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if (state !== 2'd0 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
            n_bad++; $display("FAIL idle[%0d]: got state %0d busy %b acks %b%b expected 0 0 00", i, state, busy, ack0, ack1);
         end
      end
      n_cmp++; if (rdata0 !== '0 || rdata1 !== '0) begin n_bad++; $display("FAIL idle_rdata: got %h/%h expected 0/0", rdata0, rdata1); end
   endtask

   task automatic test_lock();
      int port, cyc, cnt0, cnt1;
      exp_t e;
      logic [DW-1:0] v0, v1;
      v0 = 32'hA000_0000; v1 = 32'hB000_0000;
      cnt0 = 0; cnt1 = 0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      clear_model();
`ifdef REGARB_LOCK_EN
      lock0 = 1'b1;
      expect_xact(0, 1'b1, 2'd0, v0);
      expect_xact(0, 1'b1, 2'd0, v0 + 1);
      expect_xact(0, 1'b1, 2'd0, v0 + 2);
      expect_xact(1, 1'b1, 2'd1, v1);
`else
      expect_xact(0, 1'b1, 2'd0, v0);
      expect_xact(1, 1'b1, 2'd1, v1);
      expect_xact(0, 1'b1, 2'd0, v0 + 1);
      expect_xact(1, 1'b1, 2'd1, v1 + 1);
`endif
      drive(0, 1'b1, 2'd0, v0);
      drive(1, 1'b1, 2'd1, v1);
      for (int k = 0; k < 4; k++) begin
         wait_ack(10, port, cyc);
         e = sb_q.pop_front();
         n_cmp++; if (port !== e.port) begin n_bad++; $display("FAIL lock_order[%0d]: got port %0d expected %0d", k, port, e.port); end
         n_cmp++; if (cyc !== ((k == 0) ? 2 : 3)) begin n_bad++; $display("FAIL lock_spacing[%0d]: got %0d expected %0d", k, cyc, (k == 0) ? 2 : 3); end
         if (port == 0) begin
            cnt0++;
            if (cnt0 == 3) begin
               drop(0);
`ifdef REGARB_LOCK_EN
               lock0 = 1'b0;
`endif
            end else begin
               wdata0 = v0 + cnt0;
            end
         end else if (port == 1) begin
            cnt1++; wdata1 = v1 + cnt1;
         end
      end
      drop(0); drop(1);
`ifdef REGARB_LOCK_EN
      lock0 = 1'b0;
`endif
      @(negedge clk);
      drive(1, 1'b0, 2'd0, '0);
      expect_xact(1, 1'b0, 2'd0, '0);
      wait_ack(8, port, cyc);
      drop(1);
      e = sb_q.pop_front();
      n_cmp++; if (port !== e.port || rdata1 !== e.data) begin n_bad++; $display("FAIL lock_readback: got port %0d data %h expected port %0d data %h", port, rdata1, e.port, e.data); end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
`ifdef REGARB_LOCK_EN
      lock0 = 1'b0; lock1 = 1'b0;
`endif
      test_reset();
      test_read_zero();
      test_raw();
      test_back_to_back();
      test_reset_mid();
      test_idle();
      test_lock();
      n_cmp++; if (sb_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
